instr_fetch_stage: RTL
======================

Name: instr_fetch_stage

Overview:
- LEGv8 instruction fetch stage, directly upstream of the opcode decoder / main control.
- Holds the PC and fetches 32-bit words from instruction memory over a req/ack handshake.
- Presents a registered instruction, its PC and the 11-bit opcode field to decode.
- Supports downstream stall, one-entry skid buffering and branch redirect with squash of in-flight fetches.

Parameters:
- ADDR_W, 64, PC / memory address width
- RESET_PC, 64'h0, PC value loaded on reset

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  synchronous active-high reset
- imem_req  out  1  fetch request, registered
- imem_addr  out  ADDR_W  fetch address, registered
- imem_ack  in  1  memory returns imem_rdata this cycle
- imem_rdata  in  32  fetched instruction word
- stall  in  1  decode cannot accept this cycle
- redirect  in  1  branch taken; flush and refetch
- redirect_pc  in  ADDR_W  branch target
- if_valid  out  1  if_instr / if_pc hold a live instruction
- if_pc  out  ADDR_W  PC of if_instr
- if_instr  out  32  instruction to decode
- if_opcode  out  11  if_instr[31:21], combinational

Behaviour:
- Reset (synchronous, active-high):
  - pc=RESET_PC; imem_req=0; imem_addr=0; if_valid=0; if_pc=0; if_instr=0.
  - Skid buffer empty; drop=0; state FETCH.
  - First imem_req=1 with imem_addr=RESET_PC on the first cycle after rst deasserts.
  - rst mid-transaction abandons the outstanding request; any later ack is ignored until imem_req is reasserted.
- Handshake rules:
  - Once imem_req=1, imem_req and imem_addr stay stable until the cycle imem_ack=1.
  - imem_ack while imem_req=0 is ignored.
- Slot consumed: if_valid && !stall in the same cycle.
- State FETCH (imem_req=1):
  - On accepted ack with drop=0, pc<=pc+4 (mod 2^ADDR_W, wraps silently).
  - If the slot is empty or consumed this cycle: load slot next edge (if_valid=1, if_pc=pc, if_instr=rdata); stay FETCH; next req at pc+4 from the following cycle.
  - Otherwise: write rdata and pc into the skid buffer; go FULL; imem_req<=0.
- State FULL (imem_req=0):
  - When the slot is consumed: slot<=skid; skid empty; go FETCH; imem_req<=1 at the current pc.
- Latency: ack in cycle N gives if_valid in cycle N+1. Sustained throughput is one instruction per cycle with a single-cycle memory and no stall.
- Redirect (highest priority, overrides stall):
  - Next edge: pc<=redirect_pc; if_valid<=0; skid cleared; state FETCH.
  - If a request is outstanding and imem_ack=0 this cycle: drop<=1 and imem_req/imem_addr stay unchanged. The next ack is discarded, drop clears, and the new request issues at redirect_pc the cycle after.
  - Ack in the same cycle as redirect: data discarded, no drop; request at redirect_pc next cycle.
  - A second redirect while drop=1 updates pc only; drop stays 1.
- Stall while if_valid=0 has no effect.

Optional Feature:
- Macro: IFETCH_MISALIGN_CHK_EN.
- With the macro:
  - Extra output if_fault (1 bit, reset 0).
  - A redirect with redirect_pc[1:0]!=0 sets if_fault (sticky until rst) and clears if_valid.
  - State goes HALT: imem_req deasserts after any outstanding ack is drained, and no further fetches occur.
- Without the macro: redirect_pc[1:0] is forced to 2'b00 and there is no if_fault port.

Decomposition:
- Package if_pkg:
  - INSTR_W=32, OPCODE_MSB=31, OPCODE_LSB=21, PC_INC=4.
  - State enum {FETCH, FULL, HALT}.
- One sub-module, if_skid_slot: a single-entry pc+instr holding register with load/clear/valid.

Test Plan:
- Reset release, single-cycle memory returning 32'hF84003E1, 32'hF80003E2, stall=0 -> imem_addr 0,4,8; if_valid from the cycle after the first ack; if_opcode=11'h7C2 then 11'h7C0.
- stall=1 for 3 cycles after the first instruction -> second word lands in skid, imem_req=0 in FULL; if_pc stays 0; on release if_pc=4 then fetch resumes at 8.
- 3-cycle-latency memory, redirect to 64'h100 one cycle after req at 8 -> ack for 8 discarded; next imem_addr=64'h100; no if_valid for addr 8.
- redirect coincident with ack and stall=1 -> if_valid=0 next cycle, skid empty, imem_addr=redirect_pc.
- pc=64'hFFFF_FFFF_FFFF_FFFC fetched -> next imem_addr=0.
- With IFETCH_MISALIGN_CHK_EN, redirect_pc=64'h102 -> if_fault=1, if_valid=0, imem_req stays 0 until rst.

Source files
------------

// File: rtl/instr_fetch_stage_pkg.sv
// Shared types and constants for the LEGv8 instruction fetch stage.
// Optional misaligned-redirect checking is enabled with IFETCH_MISALIGN_CHK_EN.
package if_pkg;

    localparam int INSTR_W    = 32;
    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 21;
    localparam int OPCODE_W   = OPCODE_MSB - OPCODE_LSB + 1;
    localparam int PC_INC     = 4;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        FULL  = 2'd1,
        HALT  = 2'd2
    } fetch_state_e;

    function automatic logic [OPCODE_W-1:0] opcode_of(input logic [INSTR_W-1:0] instr);
        return instr[OPCODE_MSB:OPCODE_LSB];
    endfunction

endpackage

// File: rtl/instr_fetch_stage_if.sv
// Memory handshake plus decode-side bus of the fetch stage.
// if_fault exists only when IFETCH_MISALIGN_CHK_EN is defined.
interface instr_fetch_stage_if #(
    parameter int ADDR_W = 64
);
    import if_pkg::*;

    logic                imem_req;
    logic [ADDR_W-1:0]   imem_addr;
    logic                imem_ack;
    logic [INSTR_W-1:0]  imem_rdata;
    logic                stall;
    logic                redirect;
    logic [ADDR_W-1:0]   redirect_pc;
    logic                if_valid;
    logic [ADDR_W-1:0]   if_pc;
    logic [INSTR_W-1:0]  if_instr;
    logic [OPCODE_W-1:0] if_opcode;
`ifdef IFETCH_MISALIGN_CHK_EN
    logic                if_fault;
`endif

    modport master (
        input  imem_ack, imem_rdata, stall, redirect, redirect_pc,
        output imem_req, imem_addr, if_valid, if_pc, if_instr, if_opcode
`ifdef IFETCH_MISALIGN_CHK_EN
        , output if_fault
`endif
    );

    modport slave (
        output imem_ack, imem_rdata, stall, redirect, redirect_pc,
        input  imem_req, imem_addr, if_valid, if_pc, if_instr, if_opcode
`ifdef IFETCH_MISALIGN_CHK_EN
        , input if_fault
`endif
    );

endinterface

// File: rtl/instr_fetch_stage_skid_slot.sv
// Single-entry pc+instruction holding register used as the fetch skid buffer.
module if_skid_slot
    import if_pkg::*;
#(
    parameter int ADDR_W = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_load,
    input  logic               i_clear,
    input  logic [ADDR_W-1:0]  i_pc,
    input  logic [INSTR_W-1:0] i_instr,
    output logic               o_valid,
    output logic [ADDR_W-1:0]  o_pc,
    output logic [INSTR_W-1:0] o_instr
);

    logic               r_valid;
    logic [ADDR_W-1:0]  r_pc;
    logic [INSTR_W-1:0] r_instr;

    // Clear wins over load so a redirect always empties the entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_pc    <= {ADDR_W{1'b0}};
            r_instr <= {INSTR_W{1'b0}};
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_pc    <= i_pc;
            r_instr <= i_instr;
        end else begin
            r_valid <= r_valid;
        end
    end

    assign o_valid = r_valid;
    assign o_pc    = r_pc;
    assign o_instr = r_instr;

endmodule

// File: rtl/instr_fetch_stage.sv
// LEGv8 fetch stage: PC, req/ack fetch, registered decode slot, skid and redirect.
// Define IFETCH_MISALIGN_CHK_EN to halt with if_fault on a misaligned redirect.
module instr_fetch_stage
    import if_pkg::*;
#(
    parameter int                ADDR_W   = 64,
    parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
    input  logic                clk,
    input  logic                rst,
    instr_fetch_stage_if.master bus
);

    fetch_state_e       r_state;
    logic [ADDR_W-1:0]  r_pc;
    logic               r_req;
    logic [ADDR_W-1:0]  r_addr;
    logic               r_drop;
    logic               r_valid;
    logic [ADDR_W-1:0]  r_if_pc;
    logic [INSTR_W-1:0] r_instr;

    logic               w_consume;
    logic               w_redir;
    logic               w_misalign;
    logic [ADDR_W-1:0]  w_rpc;
    logic [ADDR_W-1:0]  w_pc_inc;
    logic               w_skid_load;
    logic               w_skid_clear;
    logic               w_skid_valid;
    logic [ADDR_W-1:0]  w_skid_pc;
    logic [INSTR_W-1:0] w_skid_instr;

    assign w_consume = r_valid & ~bus.stall;
    assign w_redir   = bus.redirect & (r_state != HALT);
    assign w_pc_inc  = r_pc + ADDR_W'(PC_INC);

`ifdef IFETCH_MISALIGN_CHK_EN
    logic r_fault;

    assign w_misalign = |bus.redirect_pc[1:0];
    assign w_rpc      = bus.redirect_pc;

    // Fault is sticky until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fault <= 1'b0;
        end else if (w_redir && w_misalign) begin
            r_fault <= 1'b1;
        end else begin
            r_fault <= r_fault;
        end
    end

    assign bus.if_fault = r_fault;
`else
    assign w_misalign = 1'b0;
    assign w_rpc      = bus.redirect_pc & ~ADDR_W'(2'b11);
`endif

    // Skid entry is filled only when data arrives into an occupied, stalled slot.
    always_comb begin
        w_skid_load  = 1'b0;
        w_skid_clear = 1'b0;
        if (w_redir) begin
            w_skid_clear = 1'b1;
        end else if ((r_state == FETCH) && r_req && bus.imem_ack && !r_drop && r_valid && bus.stall) begin
            w_skid_load = 1'b1;
        end else if ((r_state == FULL) && w_consume) begin
            w_skid_clear = 1'b1;
        end else begin
            w_skid_load  = 1'b0;
            w_skid_clear = 1'b0;
        end
    end

    if_skid_slot #(.ADDR_W(ADDR_W)) u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_skid_load),
        .i_clear (w_skid_clear),
        .i_pc    (r_pc),
        .i_instr (bus.imem_rdata),
        .o_valid (w_skid_valid),
        .o_pc    (w_skid_pc),
        .o_instr (w_skid_instr)
    );

    // Fetch FSM; an outstanding request is never withdrawn before its ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= FETCH;
            r_pc    <= RESET_PC;
            r_req   <= 1'b0;
            r_addr  <= {ADDR_W{1'b0}};
            r_drop  <= 1'b0;
            r_valid <= 1'b0;
            r_if_pc <= {ADDR_W{1'b0}};
            r_instr <= {INSTR_W{1'b0}};
        end else if (w_redir) begin
            r_valid <= 1'b0;
            if (w_misalign) begin
                r_state <= HALT;
                r_req   <= r_req & ~bus.imem_ack;
                r_drop  <= 1'b0;
            end else begin
                r_pc    <= w_rpc;
                r_state <= FETCH;
                if (r_req && !bus.imem_ack) begin
                    // Memory still owes us a word for the old path; eat it later.
                    r_drop <= 1'b1;
                end else begin
                    r_req  <= 1'b1;
                    r_addr <= w_rpc;
                    r_drop <= 1'b0;
                end
            end
        end else begin
            if (w_consume) begin
                r_valid <= 1'b0;
            end
            case (r_state)
                FETCH: begin
                    if (!r_req) begin
                        r_req  <= 1'b1;
                        r_addr <= r_pc;
                    end else if (bus.imem_ack) begin
                        if (r_drop) begin
                            r_drop <= 1'b0;
                            r_addr <= r_pc;
                        end else begin
                            r_pc <= w_pc_inc;
                            if (!r_valid || !bus.stall) begin
                                r_valid <= 1'b1;
                                r_if_pc <= r_pc;
                                r_instr <= bus.imem_rdata;
                                r_addr  <= w_pc_inc;
                            end else begin
                                r_state <= FULL;
                                r_req   <= 1'b0;
                            end
                        end
                    end
                end
                FULL: begin
                    if (w_consume) begin
                        r_valid <= w_skid_valid;
                        r_if_pc <= w_skid_pc;
                        r_instr <= w_skid_instr;
                        r_state <= FETCH;
                        r_req   <= 1'b1;
                        r_addr  <= r_pc;
                    end
                end
                HALT: begin
                    r_req <= r_req & ~bus.imem_ack;
                end
                default: begin
                    r_state <= FETCH;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.imem_req  = r_req;
    assign bus.imem_addr = r_addr;
    assign bus.if_valid  = r_valid;
    assign bus.if_pc     = r_if_pc;
    assign bus.if_instr  = r_instr;
    assign bus.if_opcode = opcode_of(r_instr);

endmodule
